mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
- Boot-time loader; the write-side counterpart of the end-of-run RF/DMEM dump.
- Accepts a byte stream over a valid/ready interface, packs bytes into 64-bit words and writes them into IMEM or DMEM.
- Holds the pipelined CPU in reset until the host sends an END command.
- Sits between the host/bench byte source and the memory write ports, and drives the CPU's reset_b.

Parameters:
DWIDTH, 64, memory word width in bits; must be a multiple of 8 (BYTES = DWIDTH/8).
AWIDTH, 8, word-address width of mem_addr.

Ports:
clk  input  1  system clock
reset_b  input  1  asynchronous active-low reset
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts the byte this cycle
mem_we  output  1  one-cycle write strobe
mem_sel  output  1  0 = IMEM, 1 = DMEM
mem_addr  output  AWIDTH  word address
mem_wdata  output  DWIDTH  write data
cpu_reset_b  output  1  active-low reset to pipeline_cpu
load_err  output  1  sticky error flag

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on reset_b.
- A byte transfers on any rising edge where in_valid && in_ready.
- Frame format: CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, then LEN*BYTES data bytes.
  - Data words are little-endian; byte 0 goes to wdata[7:0].
  - CMD values: 0x00 = IMEM, 0x01 = DMEM, 0xFF = END (END is a single byte with no fields).
- Reset values: state = S_CMD, in_ready = 0 during reset, mem_we = 0, mem_sel = 0, mem_addr = 0, mem_wdata = 0, cpu_reset_b = 0, load_err = 0, all counters 0.
- States: S_CMD, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE.
- in_ready = 1 in every state except S_WRITE and S_DONE.
- S_CMD:
  - 0x00 or 0x01: latch sel, go to S_ADDR_LO.
  - 0xFF: go to S_DONE.
  - Any other value: set load_err, stay in S_CMD (byte discarded).
- S_ADDR_LO / S_ADDR_HI: latch the 16-bit start address. mem_addr uses addr[AWIDTH-1:0]; upper bits are ignored.
- S_LEN_LO / S_LEN_HI: latch the 16-bit word count. If LEN == 0 after LEN_HI, go to S_CMD; otherwise go to S_DATA with byte_cnt = 0.
- S_DATA:
  - Each accepted byte is shifted into the word register and increments byte_cnt.
  - On the BYTES-th byte, go to S_WRITE.
- S_WRITE (exactly one cycle):
  - mem_we = 1, with mem_addr, mem_wdata and mem_sel stable and registered.
  - Next edge: addr increments (wraps modulo 2^AWIDTH), LEN decrements, byte_cnt clears.
  - If LEN becomes 0, go to S_CMD; otherwise go to S_DATA.
- Write latency: mem_we is asserted in the cycle immediately after the edge that accepted the last byte of a word.
- mem_we is 0 in all states except S_WRITE.
- S_DONE:
  - cpu_reset_b = 1 starting the cycle after the END byte is accepted.
  - Terminal state; only reset_b leaves it. in_ready = 0 and further bytes are ignored.
- in_valid low in any state: hold all state, no side effects.
- Reset mid-frame: the partial word is dropped with no write, and cpu_reset_b returns to 0 asynchronously.
- load_err is sticky until reset and does not block the END command.

Decomposition:
- loader_pkg:
  - Command constants CMD_IMEM, CMD_DMEM, CMD_END.
  - State enum ldr_state_t.
  - Constant BYTES.
- One natural sub-module, byte_packer: shift register plus byte counter with inputs shift_en and clear, and outputs word and full.

Test Plan:
- Reset, then stream 0xFF → cpu_reset_b rises exactly one cycle after acceptance; mem_we is never asserted; in_ready drops.
- Stream 00 04 00 01 00, then bytes 0x13,0x05,0x50,0x00,0,0,0,0 → a single mem_we pulse with mem_sel = 0, mem_addr = 4, mem_wdata = 0x0000000000500513; the next CMD is accepted.
- DMEM frame with ADDR = 0x00FF, LEN = 2 → writes go to addresses 0xFF then 0x00 (wrap); in_ready = 0 during each S_WRITE cycle.
- CMD 0x07, then a valid DMEM frame with LEN = 0, then 0xFF → load_err = 1, no writes, and cpu_reset_b = 1 at the end.
- in_valid toggled randomly through a 3-word frame → exactly 3 writes with correct data; no state advance in cycles where in_valid = 0.
- Assert reset_b low after 5 data bytes, then send a full frame → no write of the partial word, cpu_reset_b = 0, and the new frame writes correctly.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - shared constants, command codes and FSM state type for the boot loader
//
// Purpose: common definitions imported by the loader interface, top and sub-module.
// Ports:   none (package).
package mem_loader_pkg;

  localparam int DEF_DWIDTH = 64;
  localparam int DEF_AWIDTH = 8;
  localparam int BYTES      = DEF_DWIDTH / 8;

  localparam logic [7:0] CMD_IMEM = 8'h00;
  localparam logic [7:0] CMD_DMEM = 8'h01;
  localparam logic [7:0] CMD_END  = 8'hFF;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE
  } ldr_state_t;

endpackage

// File: rtl/mem_loader_if.sv
// rtl/mem_loader_if.sv - byte-stream input and memory write bus of the boot loader
//
// Purpose: groups the host byte handshake and the IMEM/DMEM write port.
// Modports:
//   slave  - the loader: takes in_valid/in_data, drives in_ready and the mem_* write port
//   master - the host/memory side: drives in_valid/in_data, observes everything else
// Signals:
//   in_valid, in_data[7:0], in_ready        byte handshake
//   mem_we, mem_sel, mem_addr, mem_wdata    one-cycle word write (mem_sel 0 = IMEM, 1 = DMEM)
interface mem_loader_if
  import mem_loader_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic              mem_sel;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_sel, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_sel, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// rtl/mem_loader_byte_packer.sv - little-endian byte-to-word shift register with byte counter
//
// Purpose: assembles DWIDTH/8 bytes into one word, first byte ending up in bits [7:0].
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_shift_en      shift i_byte in and count it
//   i_clear         restart the byte count (word contents are fully overwritten by the next fill)
//   i_byte[7:0]     incoming byte
//   o_word          assembled word
//   o_full          this shift completes the word (valid together with i_shift_en)
module byte_packer #(
  parameter int DWIDTH = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_shift_en,
  input  logic              i_clear,
  input  logic [7:0]        i_byte,
  output logic [DWIDTH-1:0] o_word,
  output logic              o_full
);

  localparam int BYTES = DWIDTH / 8;
  localparam int CW    = $clog2(BYTES + 1);

  logic [CW-1:0]     r_cnt;
  logic [DWIDTH-1:0] r_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else begin
      if (i_clear)
        r_cnt <= '0;
      else if (i_shift_en)
        r_cnt <= r_cnt + 1'b1;
      // Shifting in from the top leaves the first byte of the word at [7:0].
      if (i_shift_en)
        r_word <= {i_byte, r_word[DWIDTH-1:8]};
    end
  end

  // Flagged on the accepting cycle so the FSM can enter the write state on the same edge.
  assign o_full = i_shift_en && (r_cnt == CW'(BYTES - 1));
  assign o_word = r_word;

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - boot-time byte-stream loader into IMEM/DMEM, holds the CPU in reset until END
//
// Purpose: parses CMD/ADDR/LEN frames, packs data bytes into words, writes them to memory.
// Ports:
//   i_clk            system clock
//   i_reset_b        asynchronous active-low reset
//   bus (slave)      byte handshake in, memory write port out
//   o_cpu_reset_b    active-low reset to the pipeline CPU, released after END
//   o_load_err       sticky flag, set by an unknown command byte
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic        i_clk,
  input  logic        i_reset_b,
  mem_loader_if.slave bus,
  output logic        o_cpu_reset_b,
  output logic        o_load_err
);

  ldr_state_t        r_state;
  ldr_state_t        w_next;
  logic              r_sel;
  logic [15:0]       r_addr;
  logic [15:0]       r_len;
  logic              r_err;
  logic              w_ready;
  logic              w_accept;
  logic              w_shift;
  logic              w_clear;
  logic              w_full;
  logic [DWIDTH-1:0] w_word;

  // Gated by the reset pin so the host sees not-ready while reset is held.
  assign w_ready  = i_reset_b && (r_state != S_WRITE) && (r_state != S_DONE);
  assign w_accept = bus.in_valid && w_ready;
  assign w_shift  = w_accept && (r_state == S_DATA);
  assign w_clear  = (r_state == S_WRITE);

  byte_packer #(.DWIDTH(DWIDTH)) u_packer (
    .i_clk      (i_clk),
    .i_rst_n    (i_reset_b),
    .i_shift_en (w_shift),
    .i_clear    (w_clear),
    .i_byte     (bus.in_data),
    .o_word     (w_word),
    .o_full     (w_full)
  );

  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b)
      r_state <= S_CMD;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CMD: begin
        if (w_accept) begin
          if (bus.in_data == CMD_IMEM || bus.in_data == CMD_DMEM)
            w_next = S_ADDR_LO;
          else if (bus.in_data == CMD_END)
            w_next = S_DONE;
        end
      end
      S_ADDR_LO: if (w_accept) w_next = S_ADDR_HI;
      S_ADDR_HI: if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO:  if (w_accept) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_accept)
          w_next = ({bus.in_data, r_len[7:0]} == 16'd0) ? S_CMD : S_DATA;
      end
      S_DATA:  if (w_full) w_next = S_WRITE;
      S_WRITE: w_next = (r_len == 16'd1) ? S_CMD : S_DATA;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_CMD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_sel  <= 1'b0;
      r_addr <= '0;
      r_len  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_CMD: begin
          if (w_accept) begin
            if (bus.in_data == CMD_IMEM || bus.in_data == CMD_DMEM)
              r_sel <= bus.in_data[0];
            else if (bus.in_data != CMD_END)
              r_err <= 1'b1;
          end
        end
        S_ADDR_LO: if (w_accept) r_addr[7:0]  <= bus.in_data;
        S_ADDR_HI: if (w_accept) r_addr[15:8] <= bus.in_data;
        S_LEN_LO:  if (w_accept) r_len[7:0]   <= bus.in_data;
        S_LEN_HI:  if (w_accept) r_len[15:8]  <= bus.in_data;
        S_WRITE: begin
          // Only the low AWIDTH bits reach mem_addr, so this wraps modulo 2^AWIDTH there.
          r_addr <= r_addr + 16'd1;
          r_len  <= r_len - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.mem_sel   = r_sel;
  assign bus.mem_addr  = r_addr[AWIDTH-1:0];
  assign bus.mem_wdata = w_word;
  assign o_cpu_reset_b = (r_state == S_DONE);
  assign o_load_err    = r_err;

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed self-checking bench for mem_loader
module tb_mem_loader;

  logic clk;
  logic reset_b;
  logic cpu_reset_b;
  logic load_err;

  int n_checks = 0;
  int n_errors = 0;
  int ready_during_we = 0;

  typedef struct {
    logic        sel;
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t wq[$];

  mem_loader_if #(.DWIDTH(64), .AWIDTH(8)) bus ();

  mem_loader #(.DWIDTH(64), .AWIDTH(8)) dut (
    .i_clk         (clk),
    .i_reset_b     (reset_b),
    .bus           (bus),
    .o_cpu_reset_b (cpu_reset_b),
    .o_load_err    (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wq.push_back('{sel: bus.mem_sel, addr: bus.mem_addr, data: bus.mem_wdata});
      if (bus.in_ready !== 1'b0) ready_during_we++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Holds the byte valid until an edge with in_ready high; returns 1 ns after that edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got;
    int t;
    if (gaps) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hFF;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    got = 1'b0;
    t   = 0;
    while (!got && t < 50) begin
      @(negedge clk);
      got = bus.in_ready;
      t++;
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      check("accept_timeout", 64'd0, 64'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] len);
    send_byte(cmd, 1'b0);
    send_byte(addr[7:0], 1'b0);
    send_byte(addr[15:8], 1'b0);
    send_byte(len[7:0], 1'b0);
    send_byte(len[15:8], 1'b0);
  endtask

  // Sends one word LSB first and checks the write strobe one cycle after the last byte.
  task automatic send_word(input string tag, input logic [63:0] w, input logic sel,
                           input logic [7:0] addr, input bit gaps);
    logic [63:0] wv;
    wv = w;
    for (int i = 0; i < 8; i++) send_byte(wv[8*i +: 8], gaps);
    check({tag, "_we"},    {63'd0, bus.mem_we},   64'd1);
    check({tag, "_ready"}, {63'd0, bus.in_ready}, 64'd0);
    check({tag, "_sel"},   {63'd0, bus.mem_sel},  {63'd0, sel});
    check({tag, "_addr"},  {56'd0, bus.mem_addr}, {56'd0, addr});
    check({tag, "_data"},  bus.mem_wdata,         w);
    @(posedge clk);
    #1;
    check({tag, "_we_off"}, {63'd0, bus.mem_we}, 64'd0);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic sel,
                          input logic [7:0] addr, input logic [63:0] data);
    if (idx < wq.size()) begin
      check({tag, "_sel"},  {63'd0, wq[idx].sel},  {63'd0, sel});
      check({tag, "_addr"}, {56'd0, wq[idx].addr}, {56'd0, addr});
      check({tag, "_data"}, wq[idx].data,          data);
    end else begin
      check({tag, "_missing"}, 64'd0, 64'd1);
    end
  endtask

  task automatic do_reset();
    #2;
    reset_b = 1'b0;
    #1;
    check("rst_cpu_reset_b_async", {63'd0, cpu_reset_b}, 64'd0);
    check("rst_in_ready",          {63'd0, bus.in_ready}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    wq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",    {63'd0, bus.in_ready},  64'd0);
    check("reset_mem_we",      {63'd0, bus.mem_we},    64'd0);
    check("reset_mem_sel",     {63'd0, bus.mem_sel},   64'd0);
    check("reset_mem_addr",    {56'd0, bus.mem_addr},  64'd0);
    check("reset_mem_wdata",   bus.mem_wdata,          64'd0);
    check("reset_cpu_reset_b", {63'd0, cpu_reset_b},   64'd0);
    check("reset_load_err",    {63'd0, load_err},      64'd0);
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // END alone releases the CPU one cycle after acceptance.
    check("end_cpu_before", {63'd0, cpu_reset_b}, 64'd0);
    send_byte(8'hFF, 1'b0);
    check("end_cpu_after",  {63'd0, cpu_reset_b}, 64'd1);
    check("end_ready_low",  {63'd0, bus.in_ready}, 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("done_ready_low", {63'd0, bus.in_ready}, 64'd0);
    check("done_cpu_held",  {63'd0, cpu_reset_b},  64'd1);
    check("end_no_writes",  wq.size(),             64'd0);
    do_reset();

    // Single IMEM word at address 4.
    send_hdr(8'h00, 16'h0004, 16'h0001);
    send_word("imem", 64'h0000_0000_0050_0513, 1'b0, 8'h04, 1'b0);
    check("imem_count", wq.size(), 64'd1);
    check_wr("imem_wr0", 0, 1'b0, 8'h04, 64'h0000_0000_0050_0513);
    send_byte(8'hFF, 1'b0);
    check("imem_next_cmd", {63'd0, cpu_reset_b}, 64'd1);
    do_reset();

    // DMEM frame wrapping the word address, then bad command, empty frame, END.
    send_hdr(8'h01, 16'h00FF, 16'h0002);
    send_word("wrap0", 64'h1122_3344_5566_7788, 1'b1, 8'hFF, 1'b0);
    send_word("wrap1", 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 8'h00, 1'b0);
    check("wrap_count", wq.size(), 64'd2);
    check_wr("wrap_wr0", 0, 1'b1, 8'hFF, 64'h1122_3344_5566_7788);
    check_wr("wrap_wr1", 1, 1'b1, 8'h00, 64'hDEAD_BEEF_CAFE_F00D);
    check("err_before", {63'd0, load_err}, 64'd0);
    send_byte(8'h07, 1'b0);
    check("err_set", {63'd0, load_err}, 64'd1);
    send_hdr(8'h01, 16'h0010, 16'h0000);
    check("len0_cpu_low", {63'd0, cpu_reset_b}, 64'd0);
    send_byte(8'hFF, 1'b0);
    check("err_sticky",    {63'd0, load_err},    64'd1);
    check("err_end_cpu",   {63'd0, cpu_reset_b}, 64'd1);
    check("len0_no_write", wq.size(),            64'd2);
    do_reset();
    check("err_cleared", {63'd0, load_err}, 64'd0);

    // Three IMEM words with random valid gaps.
    send_hdr(8'h00, 16'h0020, 16'h0003);
    send_word("gap0", 64'h0102_0304_0506_0708, 1'b0, 8'h20, 1'b1);
    send_word("gap1", 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 8'h21, 1'b1);
    send_word("gap2", 64'hFFFF_FFFF_0000_0000, 1'b0, 8'h22, 1'b1);
    check("gap_count", wq.size(), 64'd3);
    check_wr("gap_wr2", 2, 1'b0, 8'h22, 64'hFFFF_FFFF_0000_0000);
    check("gap_back_to_cmd", {63'd0, bus.in_ready}, 64'd1);
    do_reset();

    // Reset after a partial word, then a fresh frame.
    send_hdr(8'h00, 16'h0008, 16'h0001);
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    check("partial_no_write", wq.size(),            64'd0);
    check("partial_cpu_low",  {63'd0, cpu_reset_b}, 64'd0);
    send_hdr(8'h01, 16'h0030, 16'h0001);
    send_word("fresh", 64'h0F0E_0D0C_0B0A_0908, 1'b1, 8'h30, 1'b0);
    check("fresh_count", wq.size(), 64'd1);

    check("ready_during_we", ready_during_we, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
